// File: rtl/fsm_test_sequencer.sv
// fsm_test_sequencer: replays a 16-entry {stimulus, expected} program into an FSM under test
// and scores its outputs with a one-cycle-delayed compare.
module fsm_test_sequencer (
    input  logic       TCK,
    input  logic       RESET,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic [3:0] last_idx,
    input  logic       start,
    output logic [3:0] dut_x,
    output logic       dut_rst,
    input  logic [3:0] dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] first_err_idx,
    output logic [3:0] first_err_y,
    output logic       first_err_vld
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t     state;
    logic [7:0] mem [16];
    logic [3:0] idx, last, cmp_idx;
    logic       cmp_en, mism;

    // program memory survives RESET; only the controller state is cleared
    always_ff @(posedge TCK)
        if (wr_en && state == IDLE) mem[wr_addr] <= {wr_x, wr_y};

    // idx parks on last in FLUSH, so the FLUSH compare reuses it directly
    assign cmp_en  = (state == RUN && idx != 4'd0) || state == FLUSH;
    assign cmp_idx = state == FLUSH ? idx : idx - 4'd1;
    assign mism    = cmp_en && dut_y != mem[cmp_idx][3:0];
    assign dut_x   = state == RUN ? mem[idx][7:4] : 4'd0;

    always_ff @(posedge TCK or posedge RESET)
        if (RESET) begin
            state         <= IDLE;
            idx           <= 4'd0;
            last          <= 4'd0;
            dut_rst       <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= 5'd0;
            first_err_vld <= 1'b0;
            first_err_idx <= 4'd0;
            first_err_y   <= 4'd0;
        end else begin
            if (mism) begin
                err_cnt <= err_cnt + 5'd1;
                if (!first_err_vld) begin
                    first_err_vld <= 1'b1;
                    first_err_idx <= cmp_idx;
                    first_err_y   <= dut_y;
                end
            end
            case (state)
                IDLE:
                    if (start) begin
                        state         <= RUN;
                        idx           <= 4'd0;
                        last          <= last_idx;
                        err_cnt       <= 5'd0;
                        first_err_vld <= 1'b0;
                        first_err_idx <= 4'd0;
                        first_err_y   <= 4'd0;
                        pass          <= 1'b0;
                        dut_rst       <= 1'b0;
                        busy          <= 1'b1;
                    end
                RUN:
                    if (idx == last) state <= FLUSH;
                    else idx <= idx + 4'd1;
                FLUSH: begin
                    state   <= DONE;
                    pass    <= err_cnt == 5'd0 && !mism;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    dut_rst <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_fsm_test_sequencer.sv
// tb_fsm_test_sequencer: table-driven runs of the sequencer against a small 16-state FSM model,
// plus hand sequences for held start, mid-run reset, write+start and a full 16-entry run.
module tb_fsm_test_sequencer;
    logic       TCK = 1'b0, RESET = 1'b1, wr_en = 1'b0, start = 1'b0;
    logic [3:0] wr_addr = 4'd0, wr_x = 4'd0, wr_y = 4'd0, last_idx = 4'd0;
    logic [3:0] dut_x, dut_y, first_err_idx, first_err_y, ds;
    logic       dut_rst, busy, done, pass, first_err_vld;
    logic [4:0] err_cnt;
    int         ntot = 0, npass = 0, nbusy, ndone, done_at, first_busy;
    logic [79:0] tr;
    logic       p_mid, rst_bad;

    typedef struct {
        logic [15:0] px, py;
        logic [3:0]  li;
        int          nb;
        logic [79:0] ex;
        logic [4:0]  ec;
        logic        fv;
        logic [3:0]  fi, fy;
        logic        ps;
    } vec_t;
    vec_t tv [5];

    fsm_test_sequencer u_dut (
        .TCK(TCK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
        .last_idx(last_idx), .start(start), .dut_x(dut_x), .dut_rst(dut_rst), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
        .first_err_y(first_err_y), .first_err_vld(first_err_vld)
    );

    always #5 TCK = ~TCK;

    // FSM under test: a few fixed arcs, otherwise state XOR stimulus
    function automatic logic [3:0] dnext(input logic [3:0] s, input logic [3:0] x);
        case ({s, x})
            8'h02:   return 4'h1;
            8'h1A:   return 4'h3;
            8'h3A:   return 4'h4;
            8'h4F:   return 4'h1;
            default: return s ^ x;
        endcase
    endfunction

    always @(posedge TCK) ds <= dut_rst ? 4'd0 : dnext(ds, dut_x);
    assign dut_y = ds;

    task automatic check(input string nm, input logic [79:0] a, input logic [79:0] e);
        ntot++;
        if (a === e) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    task automatic load(input logic [15:0] px, input logic [15:0] py, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_x = px[4*i +: 4]; wr_y = py[4*i +: 4];
            @(negedge TCK);
        end
        wr_en = 1'b0;
    endtask

    // start at the coming edge (edge 0); cycle c is the period after edge c-1
    task automatic run_prog(input logic [3:0] li, input bit hold, input int wcyc);
        last_idx = li; start = 1'b1;
        nbusy = 0; ndone = 0; done_at = 0; first_busy = 0; tr = '0; rst_bad = 1'b0; p_mid = 1'b1;
        @(negedge TCK);
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) p_mid = pass;
            if (busy) begin
                if (first_busy == 0) first_busy = c;
                if (nbusy < 20) tr[4*nbusy +: 4] = dut_x;
                nbusy++;
                if (dut_rst) rst_bad = 1'b1;
            end
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = c;
                if (!dut_rst) rst_bad = 1'b1;
                start = 1'b0;
            end
            wr_en = c == wcyc; wr_addr = 4'd1; wr_x = 4'd0; wr_y = 4'd0;
            if (done_at != 0 && c >= done_at + 2) break;
            @(negedge TCK);
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic check_run(input string t, input int nb, input logic [79:0] ex, input logic [4:0] ec,
                             input logic fv, input logic [3:0] fi, input logic [3:0] fy, input logic ps);
        check({t, ".busy_cycles"}, 80'(nbusy), 80'(nb));
        check({t, ".first_busy"}, 80'(first_busy), 80'd1);
        check({t, ".done_cycle"}, 80'(done_at), 80'(nb + 1));
        check({t, ".done_pulses"}, 80'(ndone), 80'd1);
        check({t, ".dut_x"}, tr, ex);
        check({t, ".dut_rst"}, 80'(rst_bad), 80'd0);
        check({t, ".pass_mid"}, 80'(p_mid), 80'd0);
        check({t, ".err_cnt"}, 80'(err_cnt), 80'(ec));
        check({t, ".first_err_vld"}, 80'(first_err_vld), 80'(fv));
        check({t, ".first_err_idx"}, 80'(first_err_idx), 80'(fi));
        check({t, ".first_err_y"}, 80'(first_err_y), 80'(fy));
        check({t, ".pass"}, 80'(pass), 80'(ps));
    endtask

    initial begin
        tv[0] = '{16'hFAA2, 16'h1431, 4'd3, 5, 80'h0FAA2, 5'd0, 1'b0, 4'd0, 4'd0, 1'b1};
        tv[1] = '{16'hFAA2, 16'h1531, 4'd3, 5, 80'h0FAA2, 5'd1, 1'b1, 4'd2, 4'd4, 1'b0};
        tv[2] = '{16'hFAA0, 16'h1431, 4'd3, 5, 80'h0FAA0, 5'd4, 1'b1, 4'd0, 4'd0, 1'b0};
        tv[3] = '{16'hFAA2, 16'h1431, 4'd1, 3, 80'h0A2,   5'd0, 1'b0, 4'd0, 4'd0, 1'b1};
        tv[4] = '{16'hFAA2, 16'h1531, 4'd2, 4, 80'h0AA2,  5'd1, 1'b1, 4'd2, 4'd4, 1'b0};

        repeat (2) @(negedge TCK);
        check("rst.busy", 80'(busy), 80'd0);
        check("rst.done", 80'(done), 80'd0);
        check("rst.dut_rst", 80'(dut_rst), 80'd1);
        check("rst.dut_x", 80'(dut_x), 80'd0);
        check("rst.pass", 80'(pass), 80'd0);
        check("rst.err_cnt", 80'(err_cnt), 80'd0);
        check("rst.first_err_vld", 80'(first_err_vld), 80'd0);
        check("rst.first_err_idx", 80'(first_err_idx), 80'd0);
        check("rst.first_err_y", 80'(first_err_y), 80'd0);
        RESET = 1'b0;
        @(negedge TCK);

        for (int i = 0; i < 5; i++) begin
            load(tv[i].px, tv[i].py, int'(tv[i].li) + 1);
            run_prog(tv[i].li, 1'b0, 0);
            check_run($sformatf("vec%0d", i), tv[i].nb, tv[i].ex, tv[i].ec, tv[i].fv, tv[i].fi, tv[i].fy, tv[i].ps);
        end

        // start held through the run and a write to entry 1 mid-run, both ignored
        load(16'hFAA2, 16'h1431, 4);
        run_prog(4'd3, 1'b1, 2);
        check_run("held", 5, 80'h0FAA2, 5'd0, 1'b0, 4'd0, 4'd0, 1'b1);
        run_prog(4'd3, 1'b0, 0);
        check_run("held_rerun", 5, 80'h0FAA2, 5'd0, 1'b0, 4'd0, 4'd0, 1'b1);

        // asynchronous reset during the idx==2 RUN cycle
        last_idx = 4'd3; start = 1'b1;
        @(negedge TCK); start = 1'b0;
        repeat (2) @(negedge TCK);
        check("abort.busy_before", 80'(busy), 80'd1);
        #1 RESET = 1'b1;
        #1;
        check("abort.busy", 80'(busy), 80'd0);
        check("abort.dut_rst", 80'(dut_rst), 80'd1);
        check("abort.dut_x", 80'(dut_x), 80'd0);
        #1 RESET = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge TCK);
            if (done || busy) ndone++;
        end
        check("abort.no_done", 80'(ndone), 80'd0);
        run_prog(4'd3, 1'b0, 0);
        check_run("abort_rerun", 5, 80'h0FAA2, 5'd0, 1'b0, 4'd0, 4'd0, 1'b1);

        // write entry 0 in the start cycle; last_idx=0
        wr_en = 1'b1; wr_addr = 4'd0; wr_x = 4'hF; wr_y = 4'hF;
        run_prog(4'd0, 1'b0, 0);
        check_run("wr_start", 2, 80'h0F, 5'd0, 1'b0, 4'd0, 4'd0, 1'b1);

        // all 16 entries, only the last one mismatches (caught by the FLUSH compare)
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_x = 4'd0; wr_y = i == 15 ? 4'd1 : 4'd0;
            @(negedge TCK);
        end
        wr_en = 1'b0;
        run_prog(4'd15, 1'b0, 0);
        check_run("full16", 17, 80'h0, 5'd1, 1'b1, 4'd15, 4'd0, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/fsm_test_sequencer.md
FSM_TEST_SEQUENCER -- requirements
Module: fsm_test_sequencer

Interface
REQ-001 The block SHALL have no parameters; the vector memory depth is fixed at 16 entries and the vector width at 4 bits.
REQ-002 The block SHALL have the following ports:
- TCK  in  1  clock; all state updates on its rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write one program entry.
- wr_addr  in  4  entry index.
- wr_x  in  4  stimulus code for the entry.
- wr_y  in  4  expected DUT output after that stimulus.
- last_idx  in  4  index of the final entry to run; run length = last_idx+1.
- start  in  1  single-cycle run request.
- dut_x  out  4  stimulus to the 16-state FSM under test.
- dut_rst  out  1  reset to the FSM under test, active-high.
- dut_y  in  4  FSM-under-test output.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  last run had zero mismatches.
- err_cnt  out  5  mismatch count of the last run (0..16).
- first_err_idx  out  4  entry index of the first mismatch.
- first_err_y  out  4  dut_y value captured at the first mismatch.
- first_err_vld  out  1  first_err_* fields are valid.

Function
REQ-003 The block SHALL hold a 16x8 program memory {x,y}, written at a rising TCK edge when wr_en=1 and the controller is in IDLE; wr_en outside IDLE SHALL be ignored.
REQ-004 The controller SHALL have the states IDLE, RUN, FLUSH and DONE.
REQ-005 IDLE: start=1 SHALL latch last_idx, set idx=0, clear err_cnt, first_err_vld, first_err_idx and first_err_y, and enter RUN; start outside IDLE SHALL be ignored.
REQ-006 A write and a start in the same cycle SHALL both take effect, and the written entry SHALL be used by the run.
REQ-007 RUN: dut_x SHALL equal mem[idx].x; idx SHALL increment each cycle; after the idx==last_idx cycle the controller SHALL enter FLUSH.
REQ-008 The comparison SHALL be pipelined by one cycle: in every RUN cycle except the first, and in FLUSH, dut_y SHALL be compared with mem[idx-1].y (in FLUSH, mem[last_idx].y).
REQ-009 On a mismatch, err_cnt SHALL increment by 1; if first_err_vld=0, the block SHALL also set first_err_vld=1, first_err_idx to the compared entry index, and first_err_y to dut_y.
REQ-010 The sequencer SHALL NOT correct the DUT after a mismatch; later entries SHALL be applied to the actual DUT state.
REQ-011 FLUSH: dut_x SHALL be 4'b0000; the next state SHALL be DONE.
REQ-012 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-013 A run SHALL occupy exactly last_idx+2 busy cycles; busy SHALL be 1 in RUN and FLUSH only.
REQ-014 dut_rst SHALL be a registered output equal to 1 in IDLE and DONE and 0 in RUN and FLUSH.
- It deasserts at the edge that enters RUN, so the DUT leaves its reset state 0000 on the first RUN cycle's closing edge.
REQ-015 dut_x SHALL be 4'b0000 in IDLE and DONE.
REQ-016 pass SHALL be updated at entry to DONE to (err_cnt==0 including the FLUSH compare) and held until the next start; pass SHALL be 0 between start and DONE.
REQ-017 err_cnt, first_err_* and pass SHALL hold their values in IDLE until the next start.
REQ-018 last_idx=15 SHALL run all 16 entries; idx SHALL NOT wrap within a run.

Reset
REQ-019 Asserting RESET SHALL force, asynchronously:
- controller state IDLE, idx=0
- dut_rst=1, dut_x=0, busy=0, done=0
- pass=0, err_cnt=0, first_err_vld=0, first_err_idx=0, first_err_y=0
REQ-020 RESET SHALL NOT alter program memory contents.
REQ-021 RESET asserted mid-run SHALL abort the run without a done pulse.

Verification
REQ-022 Program {0010/0001, 1010/0011, 1010/0100, 1111/0001}, last_idx=3, start at edge 0 -> busy cycles 1-5; dut_x 0010,1010,1010,1111,0000; done=1 in cycle 6; pass=1, err_cnt=0, first_err_vld=0.
REQ-023 Same program with entry 2 expected changed to 0101 -> err_cnt=1, first_err_idx=2, first_err_y=0100, pass=0; entry 3 still matches (0001).
REQ-024 Entry 0 set to 0000/0001 -> all 4 compares mismatch (DUT stays 0000 then diverges) -> err_cnt>=1, first_err_idx=0, first_err_y=0000.
REQ-025 start held high during a run, and wr_en to addr 1 mid-run -> no restart, memory unchanged, a single done pulse.
REQ-026 RESET pulsed during RUN idx=2 -> busy=0, dut_rst=1, no done; a new start reruns the unchanged program with identical results.
REQ-027 Write addr 0 and start in the same cycle, last_idx=0 -> the new entry 0 is applied, busy for 2 cycles, done pulse in the 3rd cycle.
